// File: rtl/serial_subtractor_if.sv
// Handshake and operand bus for serial_subtractor.
// The i_mode signal exists only when SERIAL_SUBTRACTOR_ADD_MODE_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic             i_mode;
`endif
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_diff;
  logic             o_borrow;

  modport master (
    output i_start, i_a, i_b,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    output i_mode,
`endif
    input  o_busy, o_done, o_diff, o_borrow
  );

  modport slave (
    input  i_start, i_a, i_b,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    input  i_mode,
`endif
    output o_busy, o_done, o_diff, o_borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b over WIDTH cycles, final borrow out.
// Define SERIAL_SUBTRACTOR_ADD_MODE_EN to add a mode input selecting add (carry on o_borrow).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // One bit cell: returns {borrow/carry out, result bit}.
  function automatic logic [1:0] bit_cell(input logic ai, input logic bi,
                                          input logic bri, input logic add);
    logic x;
    logic d;
    logic bo;
    x  = ai ^ bi;
    d  = x ^ bri;
    bo = add ? ((ai & bi) | (x & bri)) : ((~ai & bi) | (~x & bri));
    return {bo, d};
  endfunction

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_rs;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             w_add;
  logic [1:0]       w_cell;
  logic             w_d;
  logic             w_br_next;

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic r_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= 1'b0;
    end else if (r_state == S_IDLE && bus.i_start) begin
      r_mode <= bus.i_mode;
    end
  end

  assign w_add = r_mode;
`else
  assign w_add = 1'b0;
`endif

  assign w_cell    = bit_cell(r_sa[0], r_sb[0], r_br, w_add);
  assign w_d       = w_cell[0];
  assign w_br_next = w_cell[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_rs     <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_sa    <= bus.i_a;
            r_sb    <= bus.i_b;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_rs  <= {w_d, r_rs[WIDTH-1:1]};
          r_br  <= w_br_next;
          r_cnt <= r_cnt + 1'b1;
          // Last bit: publish the completed word and borrow in the same edge.
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_diff   <= {w_d, r_rs[WIDTH-1:1]};
            r_borrow <= w_br_next;
            r_state  <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_busy   = (r_state == S_SHIFT);
  assign bus.o_done   = (r_state == S_DONE);
  assign bus.o_diff   = r_diff;
  assign bus.o_borrow = r_borrow;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8) with directed vectors.
module tb_serial_subtractor;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   edge_cnt;
  int   done_seen;
  int   pushed;
  logic prev_done;
  logic [8:0] exp_q[$];

  serial_subtractor_if #(.WIDTH(8)) bus();

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected result per done strobe.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.o_done === 1'b1) begin
      logic [8:0] e;
      done_seen++;
      check("done_not_consecutive", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got diff=%0h borrow=%0b, required no result", bus.o_diff, bus.o_borrow);
      end else begin
        e = exp_q.pop_front();
        check("diff", {24'd0, bus.o_diff}, {24'd0, e[7:0]});
        check("borrow", {31'd0, bus.o_borrow}, {31'd0, e[8]});
      end
    end
    prev_done = (rst_n === 1'b1) ? bus.o_done : 1'b0;
  end

  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input bit add);
    logic [8:0] t;
    if (add) begin
      t = {1'b0, a} + {1'b0, b};
      return t;
    end
    t = {1'b0, a} - {1'b0, b};
    return {t[8], t[7:0]};
  endfunction

  // Drives one start pulse through the accepting edge; returns #1 after it.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit add, input bit expect_res);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    bus.i_mode  = add;
`endif
    if (expect_res) begin
      exp_q.push_back(model(a, b, add));
      pushed++;
    end
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_a     = 8'hA5;
    bus.i_b     = 8'h5A;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    bus.i_mode  = ~add;
`endif
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within 30 edges, required done");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cnt;
    int done_edge;
    int k;
    int t_done[3];
    checks    = 0;
    errors    = 0;
    edge_cnt  = 0;
    done_seen = 0;
    pushed    = 0;
    prev_done = 1'b0;
    rst_n       = 1'b0;
    bus.i_start = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    bus.i_mode  = 1'b0;
`endif
    #2;
    check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("rst_done", {31'd0, bus.o_done}, 32'd0);
    check("rst_diff", {24'd0, bus.o_diff}, 32'd0);
    check("rst_borrow", {31'd0, bus.o_borrow}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic timing: edges counted including the accepting edge.
    issue(8'h25, 8'h13, 1'b0, 1'b1);
    busy_cnt  = 0;
    done_edge = 0;
    k = 1;
    while (k < 30) begin
      if (bus.o_busy) busy_cnt++;
      if (bus.o_done) begin
        done_edge = k;
        break;
      end
      @(posedge clk);
      #1;
      k++;
    end
    check("done_latency_edges", done_edge, 9);
    check("busy_cycles", busy_cnt, 8);
    @(posedge clk);
    #1;
    check("idle_after_done", {30'd0, bus.o_busy, bus.o_done}, 32'd0);

    // Underflow, then previous result held across the next run.
    issue(8'h00, 8'h01, 1'b0, 1'b1);
    wait_done();
    issue(8'hFF, 8'hFF, 1'b0, 1'b1);
    check("hold_diff_early", {24'd0, bus.o_diff}, 32'hFF);
    repeat (4) @(posedge clk);
    #1;
    check("hold_diff_mid", {24'd0, bus.o_diff}, 32'hFF);
    check("hold_borrow_mid", {31'd0, bus.o_borrow}, 32'd1);
    wait_done();

    // start during SHIFT cycle 3 must be ignored.
    issue(8'h80, 8'h01, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_a     = 8'h10;
    bus.i_b     = 8'h10;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    wait_done();
    repeat (12) @(posedge clk);

    // Asynchronous reset mid-operation discards the run.
    issue(8'h55, 8'h0A, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("async_rst_done", {31'd0, bus.o_done}, 32'd0);
    check("async_rst_diff", {24'd0, bus.o_diff}, 32'd0);
    check("async_rst_borrow", {31'd0, bus.o_borrow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_resume_after_rst", {31'd0, bus.o_busy}, 32'd0);
    issue(8'h09, 8'h03, 1'b0, 1'b1);
    wait_done();

    // start held high: one operation every WIDTH+2 cycles.
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_a     = 8'h03;
    bus.i_b     = 8'h05;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model(8'h03, 8'h05, 1'b0));
      pushed++;
    end
    for (int i = 0; i < 3; i++) begin
      t_done[i] = -1;
      for (int j = 0; j < 30; j++) begin
        @(posedge clk);
        #1;
        if (bus.o_done) begin
          t_done[i] = edge_cnt;
          break;
        end
      end
    end
    bus.i_start = 1'b0;
    check("period_1_2", t_done[1] - t_done[0], 10);
    check("period_2_3", t_done[2] - t_done[1], 10);
    repeat (3) @(posedge clk);

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    issue(8'hF0, 8'h20, 1'b1, 1'b1);
    wait_done();
    issue(8'hF0, 8'h20, 1'b0, 1'b1);
    wait_done();
`endif

    repeat (12) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    check("done_pulse_count", done_seen, pushed);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor computing diff = a - b over WIDTH clock cycles.
- Built around a single half-subtractor/full-subtractor bit cell and a registered borrow flip-flop.
- Provides the inverse operation to the team's existing adder primitives in sequential, area-minimal form.
- Used wherever a one-bit-per-cycle arithmetic datapath is preferred over a parallel ripple array.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, bit counter width; derived, never overridden.

Ports:
- clk, input, 1, single clock; all state changes on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request pulse; sampled only in IDLE.
- a, input, WIDTH, minuend; captured on the accepting edge.
- b, input, WIDTH, subtrahend; captured on the accepting edge.
- busy, output, 1, high while state is SHIFT.
- done, output, 1, one-cycle completion strobe; high while state is DONE.
- diff, output, WIDTH, registered result; held until the next completion.
- borrow, output, 1, final borrow out (1 means a < b unsigned); held with diff.

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - state=IDLE; busy=0, done=0, diff=0, borrow=0.
  - Internal shift registers, counter and borrow flop are cleared.
  - Release is synchronous to the next clk edge; no operation resumes after reset.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at a rising edge loads sa<=a, sb<=b, br<=0, cnt<=0, then moves to SHIFT.
  - start=0 stays in IDLE.
- SHIFT, one bit per edge:
  - d = sa[0]^sb[0]^br.
  - br_next = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br).
  - sa and sb shift right by 1.
  - d shifts into the MSB of the result shift register rs (right shift).
  - cnt increments.
  - On the edge where cnt==WIDTH-1, the final bit is processed and state moves to DONE.
  - On that same edge, diff<={d, rs[WIDTH-1:1]} and borrow<=br_next.
- DONE: lasts exactly one cycle, then returns to IDLE unconditionally.
- Latency:
  - done is high exactly one cycle.
  - That cycle begins WIDTH+1 rising edges after the edge that sampled start (1 load edge + WIDTH shift edges).
  - busy is high for exactly WIDTH cycles.
- start handling:
  - start in SHIFT or DONE is ignored, not queued.
  - Operands a/b may change freely after the accepting edge.
  - Back-to-back: earliest re-accept is the first IDLE cycle after DONE, so one operation takes WIDTH+2 cycles.
- Arithmetic:
  - Unsigned modulo 2^WIDTH; diff wraps on underflow, with borrow=1.
  - Signed interpretation is left to the user; no overflow flag.
- Output stability:
  - diff and borrow change only on the SHIFT->DONE edge or on reset.
  - They hold their previous result throughout a new operation.
- Reset mid-operation: all outputs drop to 0 immediately; the partial result is discarded.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_ADD_MODE_EN.
- Defined:
  - Adds input port mode (1 bit), captured with a/b on the accepting edge.
  - mode=0: subtract exactly as above.
  - mode=1: add. d=sa[0]^sb[0]^br, br_next=(sa[0]&sb[0])|((sa[0]^sb[0])&br), and the borrow output carries the carry-out.
- Undefined: no mode port; subtract only. Timing is identical in both builds.

Test Plan (WIDTH=8):
- start with a=0x25, b=0x13 -> done high exactly 9 edges after the start edge; diff=0x12, borrow=0; busy high 8 cycles.
- a=0x00, b=0x01 -> diff=0xFF, borrow=1; then a=0xFF, b=0xFF -> diff=0x00, borrow=0; previous result held during the second run.
- Start a=0x80, b=0x01, then pulse start with a=0x10, b=0x10 during SHIFT cycle 3 -> ignored; result diff=0x7F, borrow=0; exactly one done pulse.
- Start a=0x55, b=0x0A, drive rst_n low asynchronously mid-cycle at SHIFT cycle 4 -> busy, done, diff and borrow go 0 immediately without a clock; after release, a=0x09, b=0x03 gives diff=0x06.
- start held high continuously with a=0x03, b=0x05 -> an operation every 10 cycles; each gives diff=0xFE, borrow=1; done never asserted in consecutive cycles.
- With SERIAL_SUBTRACTOR_ADD_MODE_EN: mode=1, a=0xF0, b=0x20 -> diff=0x10, borrow=1; mode=0 with the same operands -> diff=0xD0, borrow=0.
